// File: rtl/mem_channel_arbiter.sv
// rtl/mem_channel_arbiter.sv - shares NUM_CHANNELS memory channels among NUM_CONSUMERS requesters; define MEM_ARB_ROUND_ROBIN_EN for rotating priority
module mem_channel_arbiter #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 8,
   parameter int NUM_CHANNELS  = 2,
   parameter int WRITE_ENABLE  = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]            mem_read_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
   input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
   output logic [NUM_CHANNELS-1:0]            mem_write_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
   output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
   input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

   localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONSUMERS - 1);
`endif

   typedef enum logic [2:0] {
      IDLE,
      READ_WAITING,
      WRITE_WAITING,
      READ_RELAYING,
      WRITE_RELAYING
   } state_t;

   state_t                 state [NUM_CHANNELS];
   logic [IDX_W-1:0]       owner [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0] claimed;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0]       ptr [NUM_CHANNELS];
`endif

   // Unpacked views of the flat consumer/memory buses
   logic [ADDR_BITS-1:0]   rd_addr_arr [NUM_CONSUMERS];
   logic [ADDR_BITS-1:0]   wr_addr_arr [NUM_CONSUMERS];
   logic [DATA_BITS-1:0]   wr_data_arr [NUM_CONSUMERS];
   logic [DATA_BITS-1:0]   mem_rd_data_arr [NUM_CHANNELS];

   // Registered outputs
   logic [NUM_CONSUMERS-1:0] rd_ready_q;
   logic [NUM_CONSUMERS-1:0] wr_ready_q;
   logic [DATA_BITS-1:0]     rd_data_q [NUM_CONSUMERS];
   logic [NUM_CHANNELS-1:0]  mem_rd_valid_q;
   logic [NUM_CHANNELS-1:0]  mem_wr_valid_q;
   logic [ADDR_BITS-1:0]     mem_rd_addr_q [NUM_CHANNELS];
   logic [ADDR_BITS-1:0]     mem_wr_addr_q [NUM_CHANNELS];
   logic [DATA_BITS-1:0]     mem_wr_data_q [NUM_CHANNELS];

   // Grant decisions for this cycle
   logic [NUM_CONSUMERS-1:0] write_req;
   logic [NUM_CHANNELS-1:0]  grant;
   logic [NUM_CHANNELS-1:0]  grant_read;
   logic [IDX_W-1:0]         grant_idx [NUM_CHANNELS];

   // With the write path removed, write requests are never seen
   assign write_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

   for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_cons
      assign rd_addr_arr[g] = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
      assign wr_addr_arr[g] = consumer_write_address[g*ADDR_BITS +: ADDR_BITS];
      assign wr_data_arr[g] = consumer_write_data[g*DATA_BITS +: DATA_BITS];
      assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = rd_data_q[g];
   end

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
      assign mem_rd_data_arr[g] = mem_read_data[g*DATA_BITS +: DATA_BITS];
      assign mem_read_address[g*ADDR_BITS +: ADDR_BITS] = mem_rd_addr_q[g];
      assign mem_write_address[g*ADDR_BITS +: ADDR_BITS] =
         (WRITE_ENABLE != 0) ? mem_wr_addr_q[g] : '0;
      assign mem_write_data[g*DATA_BITS +: DATA_BITS] =
         (WRITE_ENABLE != 0) ? mem_wr_data_q[g] : '0;
   end

   assign consumer_read_ready  = rd_ready_q;
   assign consumer_write_ready = (WRITE_ENABLE != 0) ? wr_ready_q : '0;
   assign mem_read_valid       = mem_rd_valid_q;
   assign mem_write_valid      = (WRITE_ENABLE != 0) ? mem_wr_valid_q : '0;

   // Each idle channel, in index order, claims the first pending unclaimed consumer from its pointer;
   // a consumer taken by a lower channel is hidden from higher ones in the same cycle
   always_comb begin
      logic [NUM_CONSUMERS-1:0] taken;
      logic [IDX_W-1:0]         kk;
      int                       start;
      int                       k;
      taken = claimed;
      kk    = '0;
      start = 0;
      k     = 0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         grant[c]      = 1'b0;
         grant_read[c] = 1'b0;
         grant_idx[c]  = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         start = int'(ptr[c]);
`endif
         if (state[c] == IDLE) begin
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
               k = start + i;
               if (k >= NUM_CONSUMERS) k = k - NUM_CONSUMERS;
               kk = IDX_W'(k);
               if (!grant[c] && !taken[kk] && (consumer_read_valid[kk] || write_req[kk])) begin
                  grant[c]      = 1'b1;
                  grant_idx[c]  = kk;
                  grant_read[c] = consumer_read_valid[kk];
               end
            end
         end
         if (grant[c]) taken[grant_idx[c]] = 1'b1;
      end
   end

   // Per-channel FSMs: claim, relay to memory, hand the response back, release on consumer valid drop
   always_ff @(posedge clk) begin
      if (reset) begin
         claimed        <= '0;
         rd_ready_q     <= '0;
         wr_ready_q     <= '0;
         mem_rd_valid_q <= '0;
         mem_wr_valid_q <= '0;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state[c]         <= IDLE;
            owner[c]         <= '0;
            mem_rd_addr_q[c] <= '0;
            mem_wr_addr_q[c] <= '0;
            mem_wr_data_q[c] <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr[c]           <= '0;
`endif
         end
         for (int i = 0; i < NUM_CONSUMERS; i++) begin
            rd_data_q[i] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (state[c])
               IDLE: begin
                  if (grant[c]) begin
                     claimed[grant_idx[c]] <= 1'b1;
                     owner[c]              <= grant_idx[c];
`ifdef MEM_ARB_ROUND_ROBIN_EN
                     ptr[c] <= (grant_idx[c] == LAST_IDX) ? '0 : grant_idx[c] + IDX_W'(1);
`endif
                     if (grant_read[c]) begin
                        mem_rd_valid_q[c] <= 1'b1;
                        mem_rd_addr_q[c]  <= rd_addr_arr[grant_idx[c]];
                        state[c]          <= READ_WAITING;
                     end else begin
                        mem_wr_valid_q[c] <= 1'b1;
                        mem_wr_addr_q[c]  <= wr_addr_arr[grant_idx[c]];
                        mem_wr_data_q[c]  <= wr_data_arr[grant_idx[c]];
                        state[c]          <= WRITE_WAITING;
                     end
                  end
               end
               READ_WAITING: begin
                  if (mem_read_ready[c]) begin
                     mem_rd_valid_q[c]     <= 1'b0;
                     rd_data_q[owner[c]]   <= mem_rd_data_arr[c];
                     rd_ready_q[owner[c]]  <= 1'b1;
                     state[c]              <= READ_RELAYING;
                  end
               end
               WRITE_WAITING: begin
                  if (mem_write_ready[c]) begin
                     mem_wr_valid_q[c]     <= 1'b0;
                     wr_ready_q[owner[c]]  <= 1'b1;
                     state[c]              <= WRITE_RELAYING;
                  end
               end
               READ_RELAYING: begin
                  if (!consumer_read_valid[owner[c]]) begin
                     rd_ready_q[owner[c]] <= 1'b0;
                     claimed[owner[c]]    <= 1'b0;
                     state[c]             <= IDLE;
                  end
               end
               WRITE_RELAYING: begin
                  if (!consumer_write_valid[owner[c]]) begin
                     wr_ready_q[owner[c]] <= 1'b0;
                     claimed[owner[c]]    <= 1'b0;
                     state[c]             <= IDLE;
                  end
               end
               default: state[c] <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// tb/tb_mem_channel_arbiter.sv - self-checking bench for mem_channel_arbiter
module tb_mem_channel_arbiter;

   localparam int A   = 8;
   localparam int D   = 8;
   localparam int NC  = 8;
   localparam int NCH = 2;

   logic clk = 1'b0;
   logic reset;
   logic [NC-1:0]    crv, cwv, crr, cwr;
   logic [NC*A-1:0]  cra, cwa;
   logic [NC*D-1:0]  cwd, crd;
   logic [NCH-1:0]   mrv, mwv, mrr, mwr;
   logic [NCH*A-1:0] mra, mwa;
   logic [NCH*D-1:0] mrd, mwd;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_channel_arbiter #(
      .ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .WRITE_ENABLE(1)
   ) dut (
      .clk(clk), .reset(reset),
      .consumer_read_valid(crv), .consumer_read_address(cra),
      .consumer_read_ready(crr), .consumer_read_data(crd),
      .consumer_write_valid(cwv), .consumer_write_address(cwa),
      .consumer_write_data(cwd), .consumer_write_ready(cwr),
      .mem_read_valid(mrv), .mem_read_address(mra),
      .mem_read_ready(mrr), .mem_read_data(mrd),
      .mem_write_valid(mwv), .mem_write_address(mwa),
      .mem_write_data(mwd), .mem_write_ready(mwr)
   );

   typedef struct {
      logic [7:0]  rv;
      logic [7:0]  wv;
      logic [1:0]  mrv;
      logic [1:0]  mwv;
      logic [15:0] ra;
      logic [15:0] wa;
      logic [15:0] wd;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      crv = '0; cwv = '0; mrr = '0; mwr = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic set_default_addrs();
      for (int i = 0; i < NC; i++) begin
         cra[i*A +: A] = 8'h40 + 8'(i);
         cwa[i*A +: A] = 8'h10 + 8'(i);
         cwd[i*D +: D] = 8'h70 + 8'(i);
      end
   endtask

   // Random-phase reference state
   logic [7:0] mem_model [256];
   int         cst [NC];
   int         gap [NC];
   int         age [NC];
   logic [7:0] caddr [NC];
   logic [7:0] wdat [NC];
   logic [NC-1:0] served;
   int         ph_r [NCH], lat_r [NCH], ph_w [NCH], lat_w [NCH];
   logic [7:0] radr [NCH], wadr [NCH];

   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      vec_t tbl [9];
      int   grants, first7, id, completions;
      logic [31:0] tmp;
      bit   draining;

      reset = 1'b1;
      crv = '0; cwv = '0; mrr = '0; mwr = '0; mrd = '0;
      set_default_addrs();

      tbl[0] = '{8'h08, 8'h00, 2'b01, 2'b00, 16'h0043, 16'h0000, 16'h0000};
      tbl[1] = '{8'h0F, 8'h00, 2'b11, 2'b00, 16'h4140, 16'h0000, 16'h0000};
      tbl[2] = '{8'h80, 8'h00, 2'b01, 2'b00, 16'h0047, 16'h0000, 16'h0000};
      tbl[3] = '{8'h00, 8'h20, 2'b00, 2'b01, 16'h0000, 16'h0015, 16'h0075};
      tbl[4] = '{8'h02, 8'h02, 2'b01, 2'b00, 16'h0041, 16'h0000, 16'h0000};
      tbl[5] = '{8'h02, 8'h01, 2'b10, 2'b01, 16'h4100, 16'h0010, 16'h0070};
      tbl[6] = '{8'hC0, 8'h00, 2'b11, 2'b00, 16'h4746, 16'h0000, 16'h0000};
      tbl[7] = '{8'h00, 8'h00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000};
      tbl[8] = '{8'h00, 8'h18, 2'b00, 2'b11, 16'h0000, 16'h1413, 16'h7473};

      // Reset state
      do_reset();
      check("reset_mrv", mrv, 0);
      check("reset_mwv", mwv, 0);
      check("reset_mra", mra, 0);
      check("reset_mwa", mwa, 0);
      check("reset_mwd", mwd, 0);
      check("reset_crr", crr, 0);
      check("reset_cwr", cwr, 0);
      check("reset_crd", crd, 0);

      // First-grant selection table, each row from reset
      for (int r = 0; r < 9; r++) begin
         do_reset();
         crv = tbl[r].rv;
         cwv = tbl[r].wv;
         step();
         check($sformatf("tbl%0d_mrv", r), mrv, tbl[r].mrv);
         check($sformatf("tbl%0d_mwv", r), mwv, tbl[r].mwv);
         check($sformatf("tbl%0d_mra", r), mra, tbl[r].ra);
         check($sformatf("tbl%0d_mwa", r), mwa, tbl[r].wa);
         check($sformatf("tbl%0d_mwd", r), mwd, tbl[r].wd);
      end

      // Single read: consumer 3, address 0x42, data 0xA5
      do_reset();
      cra[3*A +: A] = 8'h42;
      crv = 8'h08;
      step();
      check("a_mrv_rise", mrv, 2'b01);
      check("a_mra", mra[7:0], 8'h42);
      step();
      check("a_mrv_hold", mrv, 2'b01);
      check("a_crr_early", crr, 0);
      mrd[7:0] = 8'hA5;
      mrr = 2'b01;
      step();
      mrr = '0;
      check("a_crr", crr, 8'h08);
      check("a_crd", crd[3*D +: D], 8'hA5);
      check("a_mrv_drop", mrv, 0);
      step();
      check("a_crr_held", crr, 8'h08);
      crv = '0;
      step();
      check("a_crr_clear", crr, 0);
      set_default_addrs();

      // Contention: 0..3 request together
      do_reset();
      crv = 8'h0F;
      step();
      check("b_mrv", mrv, 2'b11);
      check("b_mra_r1", mra, 16'h4140);
      mrr = 2'b11;
      step();
      mrr = '0;
      check("b_crr_r1", crr, 8'h03);
      crv = 8'h0C;
      step();
      check("b_crr_clear", crr, 0);
      check("b_mrv_idle", mrv, 0);
      step();
      check("b_mrv_r2", mrv, 2'b11);
      check("b_mra_r2", mra, 16'h4342);

      // Write: consumer 5 writes 0x7E to 0x10
      do_reset();
      cwa[5*A +: A] = 8'h10;
      cwd[5*D +: D] = 8'h7E;
      cwv = 8'h20;
      step();
      check("c_mwv", mwv, 2'b01);
      check("c_mwa", mwa[7:0], 8'h10);
      check("c_mwd", mwd[7:0], 8'h7E);
      mwr = 2'b01;
      step();
      mwr = '0;
      check("c_cwr", cwr, 8'h20);
      check("c_mwv_drop", mwv, 0);
      cwv = '0;
      step();
      check("c_cwr_clear", cwr, 0);
      set_default_addrs();

      // Read and write on the same consumer: read first, write on the next claim
      do_reset();
      crv = 8'h02;
      cwv = 8'h02;
      step();
      check("d_mrv", mrv, 2'b01);
      check("d_mwv_none", mwv, 0);
      check("d_mra", mra[7:0], 8'h41);
      mrd[7:0] = 8'h3C;
      mrr = 2'b01;
      step();
      mrr = '0;
      check("d_crr", crr, 8'h02);
      check("d_cwr_none", cwr, 0);
      check("d_crd", crd[1*D +: D], 8'h3C);
      crv = '0;
      step();
      check("d_crr_clear", crr, 0);
      check("d_mwv_wait", mwv, 0);
      step();
      check("d_mwv", mwv, 2'b01);
      check("d_mwa", mwa[7:0], 8'h11);
      mwr = 2'b01;
      step();
      mwr = '0;
      check("d_cwr", cwr, 8'h02);
      cwv = '0;
      step();
      check("d_cwr_clear", cwr, 0);

      // Reset while channel 0 waits on memory
      do_reset();
      crv = 8'h04;
      step();
      check("e_mrv", mrv, 2'b01);
      reset = 1'b1;
      step();
      check("e_rst_mrv", mrv, 0);
      check("e_rst_mra", mra, 0);
      check("e_rst_crr", crr, 0);
      reset = 1'b0;
      step();
      check("e_mrv_again", mrv, 2'b01);
      check("e_mra_again", mra[7:0], 8'h42);
      mrd[7:0] = 8'h99;
      mrr = 2'b01;
      step();
      mrr = '0;
      check("e_crr", crr, 8'h04);
      check("e_crd", crd[2*D +: D], 8'h99);
      crv = '0;
      step();
      check("e_crr_clear", crr, 0);

      // Fairness: consumers 0 and 1 re-request at once, consumer 7 stays pending
      do_reset();
      crv = 8'h83;
      grants = 0;
      first7 = -1;
      for (int cyc = 0; cyc < 200 && grants < 8; cyc++) begin
         step();
         for (int c = 0; c < NCH; c++) begin
            if (mrv[c]) begin
               grants++;
               id = int'(mra[c*A +: 3]);
               if (id == 7 && first7 < 0) first7 = grants;
            end
            mrr[c] = mrv[c];
         end
         crv[0] = !crr[0];
         crv[1] = !crr[1];
         if (crr[7]) crv[7] = 1'b0;
      end
      check("f_grant_count", grants, 8);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      check("f_c7_within_8", (first7 > 0 && first7 <= 8), 1'b1);
`else
      check("f_c7_starved", first7, -1);
`endif

      // Randomized traffic against a reference memory and consumer model
      do_reset();
      for (int j = 0; j < 256; j++) mem_model[j] = 8'($urandom);
      for (int i = 0; i < NC; i++) begin
         cst[i] = 0; gap[i] = $urandom_range(0, 20); age[i] = 0;
      end
      for (int c = 0; c < NCH; c++) begin
         ph_r[c] = 0; ph_w[c] = 0; lat_r[c] = 0; lat_w[c] = 0;
      end
      served = '0;
      completions = 0;
      draining = 1'b0;
      for (int cyc = 0; cyc < 2600; cyc++) begin
         step();
         if (cyc >= 2000) draining = 1'b1;
         for (int c = 0; c < NCH; c++) begin
            case (ph_r[c])
               2: begin
                  mrr[c] = 1'b0; ph_r[c] = 0;
                  check("rnd_rd_valid_drop", mrv[c], 1'b0);
               end
               1: begin
                  check("rnd_rd_addr_stable", mra[c*A +: A], radr[c]);
                  if (lat_r[c] == 0) begin
                     mrr[c] = 1'b1; mrd[c*D +: D] = mem_model[radr[c]]; ph_r[c] = 2;
                  end else lat_r[c]--;
               end
               default: if (mrv[c]) begin
                  radr[c] = mra[c*A +: A];
                  id = int'(radr[c][2:0]);
                  check("rnd_rd_grant", (cst[id] == 1 && !served[id]), 1'b1);
                  served[id] = 1'b1;
                  lat_r[c] = $urandom_range(0, 3); ph_r[c] = 1;
               end
            endcase
            case (ph_w[c])
               2: begin
                  mwr[c] = 1'b0; ph_w[c] = 0;
                  check("rnd_wr_valid_drop", mwv[c], 1'b0);
               end
               1: begin
                  check("rnd_wr_addr_stable", mwa[c*A +: A], wadr[c]);
                  if (lat_w[c] == 0) begin
                     mwr[c] = 1'b1; mem_model[wadr[c]] = mwd[c*D +: D]; ph_w[c] = 2;
                  end else lat_w[c]--;
               end
               default: if (mwv[c]) begin
                  wadr[c] = mwa[c*A +: A];
                  id = int'(wadr[c][2:0]);
                  check("rnd_wr_grant", (cst[id] == 2 && !served[id]), 1'b1);
                  served[id] = 1'b1;
                  lat_w[c] = $urandom_range(0, 3); ph_w[c] = 1;
               end
            endcase
         end
         for (int i = 0; i < NC; i++) begin
            case (cst[i])
               0: begin
                  check("rnd_idle_ready", {crr[i], cwr[i]}, 2'b00);
                  if (!draining) begin
                     if (gap[i] > 0) gap[i]--;
                     else begin
                        tmp = $urandom;
                        caddr[i] = {tmp[4:0], 3'(i)};
                        age[i] = 0;
                        if (tmp[8]) begin
                           cra[i*A +: A] = caddr[i]; crv[i] = 1'b1; cst[i] = 1;
                        end else begin
                           wdat[i] = tmp[23:16];
                           cwa[i*A +: A] = caddr[i]; cwd[i*D +: D] = wdat[i];
                           cwv[i] = 1'b1; cst[i] = 2;
                        end
                     end
                  end
               end
               1, 2: begin
                  age[i]++;
                  if (cst[i] == 1 && crr[i]) begin
                     check("rnd_rd_data", crd[i*D +: D], mem_model[caddr[i]]);
                     crv[i] = 1'b0; served[i] = 1'b0; cst[i] = 3; completions++;
                  end else if (cst[i] == 2 && cwr[i]) begin
                     check("rnd_wr_data", mem_model[caddr[i]], wdat[i]);
                     cwv[i] = 1'b0; served[i] = 1'b0; cst[i] = 3; completions++;
                  end else if (age[i] > 300) begin
                     total++; bad++;
                     $display("FAIL rnd_timeout consumer=%0d actual=%0d cycles required<=300", i, age[i]);
                     crv[i] = 1'b0; cwv[i] = 1'b0; cst[i] = 0; gap[i] = 1000000;
                  end
               end
               default: begin
                  check("rnd_ready_clear", {crr[i], cwr[i]}, 2'b00);
                  cst[i] = 0;
                  gap[i] = $urandom_range(10, 60);
               end
            endcase
         end
      end
      for (int i = 0; i < NC; i++) check($sformatf("rnd_drained%0d", i), cst[i], 0);
      check("rnd_enough_traffic", (completions >= 100), 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_channel_arbiter.md
Name: mem_channel_arbiter

Overview:
- Shares a small number of external memory channels among many memory requesters (per-thread LSUs across all cores, or per-core fetchers).
- Sits between the compute cores and the external data/program memory.
- Each channel runs an independent FSM that claims one pending request, relays it to memory, and returns the response.
- The block enforces the consumer-side valid/ready handshake used throughout the GPU.

Parameters:
- ADDR_BITS, 8, memory address width.
- DATA_BITS, 8, memory data width.
- NUM_CONSUMERS, 8, number of requesters.
- NUM_CHANNELS, 2, number of concurrent external memory channels (1..NUM_CONSUMERS).
- WRITE_ENABLE, 1, when 0 the write path is removed and write ports are tied off (ready=0, valid=0).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- consumer_read_valid  in  [NUM_CONSUMERS]  read request pending.
- consumer_read_address  in  [ADDR_BITS] x NUM_CONSUMERS  read address.
- consumer_read_ready  out  [NUM_CONSUMERS]  read data valid; held until consumer drops valid.
- consumer_read_data  out  [DATA_BITS] x NUM_CONSUMERS  returned data.
- consumer_write_valid  in  [NUM_CONSUMERS]  write request pending.
- consumer_write_address  in  [ADDR_BITS] x NUM_CONSUMERS  write address.
- consumer_write_data  in  [DATA_BITS] x NUM_CONSUMERS  write data.
- consumer_write_ready  out  [NUM_CONSUMERS]  write complete; held until consumer drops valid.
- mem_read_valid  out  [NUM_CHANNELS]  channel read request.
- mem_read_address  out  [ADDR_BITS] x NUM_CHANNELS  channel read address.
- mem_read_ready  in  [NUM_CHANNELS]  memory read done.
- mem_read_data  in  [DATA_BITS] x NUM_CHANNELS  memory read data.
- mem_write_valid  out  [NUM_CHANNELS]  channel write request.
- mem_write_address  out  [ADDR_BITS] x NUM_CHANNELS  channel write address.
- mem_write_data  out  [DATA_BITS] x NUM_CHANNELS  channel write data.
- mem_write_ready  in  [NUM_CHANNELS]  memory write done.

Behaviour:
- Reset: all outputs are 0. Every channel goes to IDLE. The claim mask is cleared. Round-robin pointers are 0. Reset mid-transaction abandons the transaction with no response.
- Per-channel states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- IDLE:
  - Scan consumers starting at the channel's pointer, wrapping modulo NUM_CONSUMERS.
  - Take the first consumer with read_valid or write_valid that is not claimed.
  - Set its claim bit, latch the consumer index, and drive the mem request registers.
  - Read wins over write if both are asserted for the same consumer.
- Channel order: channels are evaluated in index order within one cycle. A consumer claimed by channel c is invisible to channels greater than c in the same cycle, so there is never a double grant.
- READ_WAITING / WRITE_WAITING:
  - Hold mem_*_valid=1 with a stable address/data.
  - On mem_*_ready=1: drop mem_*_valid.
  - For reads, register mem_read_data into consumer_read_data.
  - Assert consumer_*_ready for the latched consumer, then go to *_RELAYING.
- *_RELAYING:
  - When the consumer's *_valid is 0: clear consumer_*_ready and the claim bit, then return to IDLE.
  - The channel may grant again on the next cycle.
- Latency:
  - Request first visible at cycle N -> mem_*_valid=1 at N+1.
  - mem_*_ready at cycle M -> consumer_*_ready=1 at M+1.
- Ignored inputs: mem_*_ready while a channel is not in the matching WAITING state. Consumer valid deasserted while in WAITING (the request completes anyway, and the ready pulse drops one cycle after RELAYING is entered).
- Idle channels: no requests means all channels stay in IDLE with outputs at 0.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: after a grant to consumer k, that channel's pointer becomes (k+1) mod NUM_CONSUMERS. This gives fair rotation.
- Undefined: pointers are fixed at 0 (strict priority, lowest consumer index wins) and the pointer registers are not synthesized.

Test Plan:
- Single read: consumer 3 reads addr 0x42 and memory returns 0xA5 after 2 cycles -> mem_read_valid[0] rises one cycle after request, consumer_read_ready[3]=1 with data 0xA5 one cycle after mem ready, and ready clears one cycle after valid drops.
- Contention: consumers 0,1,2,3 all read in the same cycle with 2 channels -> ch0 serves 0 and ch1 serves 1. With ROUND_ROBIN_EN, the second round serves 2,3. Without it, 2,3 are served once 0,1 drop valid.
- Write: consumer 5 writes 0x7E to 0x10 -> mem_write_valid/address/data match, and consumer_write_ready[5] is asserted after mem_write_ready.
- Read+write same consumer: both valid on consumer 1 -> read serviced first, write serviced on the next claim.
- Reset mid-operation: reset asserted while ch0 is in READ_WAITING -> next cycle all outputs are 0. A new request after reset is served normally.
- Fairness: consumer 0 re-requests immediately after each completion while consumer 7 is pending, with NUM_CHANNELS=1 and RR enabled -> consumer 7 is granted within 8 grants.
